// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel clock-enable, DrawX/DrawY, syncs, blank and strobes.
// Levels are registered from next-state counters; Enable=0 freezes everything and masks pixel_ce/strobes.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CLK_DIV  = 2,
  parameter int CW       = 10
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Enable,
  output logic          pixel_ce,
  output logic [CW-1:0] DrawX,
  output logic [CW-1:0] DrawY,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if ((1 << CW) <= H_TOTAL || (1 << CW) <= V_TOTAL) begin : g_bad_cw
      $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
    end
  endgenerate

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          blank_q, blank_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          pce;
  logic          h_wrap;
  logic          v_wrap;

  always_comb begin
    pce           = Enable && (div_q == DIV_LAST);
    h_wrap        = (x_q == H_LAST);
    v_wrap        = (y_q == V_LAST);
    div_d         = div_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (Enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
    end

    if (pce) begin
      if (h_wrap) begin
        x_d          = '0;
        y_d          = v_wrap ? '0 : y_q + CW'(1);
        line_start_d = 1'b1;
        frame_start_d = v_wrap;
      end else begin
        x_d = x_q + CW'(1);
      end
    end

    // Levels decode the next-state counters so they land on the same edge as DrawX/DrawY.
    hs_d    = (x_d >= HS_START && x_d < HS_END) ? HS_POL : ~HS_POL;
    vs_d    = (y_d >= VS_START && y_d < VS_END) ? VS_POL : ~VS_POL;
    blank_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      hs_q          <= ~HS_POL;
      vs_q          <= ~VS_POL;
      blank_q       <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Strobes are masked while held so a freeze never shows a stale line/frame start.
  assign pixel_ce    = pce;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign sync        = 1'b0;
  assign line_start  = line_start_q && Enable;
  assign frame_start = frame_start_q && Enable;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: vector table on a tiny raster plus sequences on default-width rasters.
module tb_vga_timing_gen;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Small raster: H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, positive syncs.
  logic       s_rst = 1'b1, s_en = 1'b0;
  logic       s_pce, s_hs, s_vs, s_blank, s_sync, s_ls, s_fs;
  logic [3:0] s_x, s_y;
  vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
                   .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
                   .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(4)) u_small (
    .Clk(Clk), .Reset(s_rst), .Enable(s_en), .pixel_ce(s_pce), .DrawX(s_x), .DrawY(s_y),
    .hs(s_hs), .vs(s_vs), .blank(s_blank), .sync(s_sync), .line_start(s_ls), .frame_start(s_fs));

  // Default timing.
  logic       d_rst = 1'b1, d_en = 1'b0;
  logic       d_pce, d_hs, d_vs, d_blank, d_sync, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  vga_timing_gen u_def (
    .Clk(Clk), .Reset(d_rst), .Enable(d_en), .pixel_ce(d_pce), .DrawX(d_x), .DrawY(d_y),
    .hs(d_hs), .vs(d_vs), .blank(d_blank), .sync(d_sync), .line_start(d_ls), .frame_start(d_fs));

  // Default horizontal timing with a 6-line frame (vs low on line 4).
  logic       m_rst = 1'b1, m_en = 1'b0;
  logic       m_pce, m_hs, m_vs, m_blank, m_sync, m_ls, m_fs;
  logic [9:0] m_x, m_y;
  vga_timing_gen #(.V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) u_mid (
    .Clk(Clk), .Reset(m_rst), .Enable(m_en), .pixel_ce(m_pce), .DrawX(m_x), .DrawY(m_y),
    .hs(m_hs), .vs(m_vs), .blank(m_blank), .sync(m_sync), .line_start(m_ls), .frame_start(m_fs));

  typedef struct packed {
    logic       rst;
    logic       en;
    logic [7:0] n;
    logic [3:0] x;
    logic [3:0] y;
    logic       hs, vs, blank, pce, ls, fs;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic en, input int n, input int x, input int y,
                              input logic hs, input logic vs, input logic b, input logic p,
                              input logic ls, input logic fs);
    vec_t v;
    v.rst = rst; v.en = en; v.n = 8'(n); v.x = 4'(x); v.y = 4'(y);
    v.hs = hs; v.vs = vs; v.blank = b; v.pce = p; v.ls = ls; v.fs = fs;
    return v;
  endfunction

  vec_t tbl [24];

  initial begin
    int rx, ry, bad_xy, bad_hs, bad_vs, bad_bl, bad_pce, bad_ls, bad_fs, last_fs, fs_cnt;
    logic e_hs, e_vs, e_bl, e_ls, e_fs, e_pce;

    //            rst en  n   x  y  hs vs bl pce ls fs
    tbl[0]  = mk(1, 1, 1,  0, 0, 0, 0, 1, 1, 0, 0);
    tbl[1]  = mk(0, 1, 1,  1, 0, 0, 0, 1, 1, 0, 0);
    tbl[2]  = mk(0, 1, 3,  4, 0, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(0, 1, 1,  5, 0, 1, 0, 0, 1, 0, 0);
    tbl[4]  = mk(0, 1, 2,  7, 0, 0, 0, 0, 1, 0, 0);
    tbl[5]  = mk(0, 1, 1,  0, 1, 0, 0, 1, 1, 1, 0);
    tbl[6]  = mk(0, 1, 1,  1, 1, 0, 0, 1, 1, 0, 0);
    tbl[7]  = mk(0, 0, 1,  1, 1, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 0, 3,  1, 1, 0, 0, 1, 0, 0, 0);
    tbl[9]  = mk(0, 1, 1,  2, 1, 0, 0, 1, 1, 0, 0);
    tbl[10] = mk(0, 1, 22, 0, 4, 0, 1, 0, 1, 1, 0);
    tbl[11] = mk(0, 1, 5,  5, 4, 1, 1, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, 3,  0, 5, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(0, 1, 7,  7, 5, 0, 0, 0, 1, 0, 0);
    tbl[14] = mk(0, 1, 1,  0, 0, 0, 0, 1, 1, 1, 1);
    tbl[15] = mk(0, 1, 1,  1, 0, 0, 0, 1, 1, 0, 0);
    tbl[16] = mk(0, 1, 47, 0, 0, 0, 0, 1, 1, 1, 1);
    tbl[17] = mk(0, 1, 37, 5, 4, 1, 1, 0, 1, 0, 0);
    tbl[18] = mk(1, 1, 1,  0, 0, 0, 0, 1, 1, 0, 0);
    tbl[19] = mk(0, 1, 1,  1, 0, 0, 0, 1, 1, 0, 0);
    tbl[20] = mk(0, 1, 47, 0, 0, 0, 0, 1, 1, 1, 1);
    tbl[21] = mk(0, 1, 3,  3, 0, 0, 0, 1, 1, 0, 0);
    tbl[22] = mk(1, 0, 1,  0, 0, 0, 0, 1, 0, 0, 0);
    tbl[23] = mk(0, 1, 1,  1, 0, 0, 0, 1, 1, 0, 0);

    // Table: inputs set at a falling edge, n rising edges, outputs sampled at the falling edge.
    @(negedge Clk);
    for (int i = 0; i < 24; i++) begin
      s_rst = tbl[i].rst;
      s_en  = tbl[i].en;
      repeat (int'(tbl[i].n)) @(negedge Clk);
      check($sformatf("small_vec%0d {x,y,hs,vs,blank,pce,ls,fs}", i),
            {s_x, s_y, s_hs, s_vs, s_blank, s_pce, s_ls, s_fs},
            {tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].blank, tbl[i].pce, tbl[i].ls, tbl[i].fs});
    end
    check("small_sync_tied", s_sync, 1'b0);

    // Default timing: one reset edge, then scan two lines against a pixel-count reference.
    d_rst = 1'b1; d_en = 1'b1;
    @(negedge Clk); @(negedge Clk);
    d_rst = 1'b0;
    check("def_reset_state {x,y,hs,vs,blank,pce,ls,fs}",
          {d_x, d_y, d_hs, d_vs, d_blank, d_pce, d_ls, d_fs},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    bad_xy = 0; bad_hs = 0; bad_bl = 0; bad_pce = 0; bad_ls = 0; bad_fs = 0;
    for (int k = 1; k <= 3300; k++) begin
      @(negedge Clk);
      rx    = (k / 2) % 800;
      ry    = k / 1600;
      e_pce = (k % 2) == 1;
      e_hs  = !(rx >= 656 && rx <= 751);
      e_bl  = rx < 640;
      e_ls  = (k % 1600) == 0;
      if (d_x !== 10'(rx) || d_y !== 10'(ry)) bad_xy++;
      if (d_pce !== e_pce) bad_pce++;
      if (d_hs !== e_hs) bad_hs++;
      if (d_blank !== e_bl) bad_bl++;
      if (d_ls !== e_ls) bad_ls++;
      if (d_fs !== 1'b0) bad_fs++;
      if (k == 1599) check("def_line_end {x,y,pce}", {d_x, d_y, d_pce}, {10'd799, 10'd0, 1'b1});
      if (k == 1600) check("def_line_wrap {x,y,ls}", {d_x, d_y, d_ls}, {10'd0, 10'd1, 1'b1});
    end
    check("def_scan_xy_bad_samples", bad_xy, 0);
    check("def_scan_pce_bad_samples", bad_pce, 0);
    check("def_scan_hs_bad_samples", bad_hs, 0);
    check("def_scan_blank_bad_samples", bad_bl, 0);
    check("def_scan_line_start_bad_samples", bad_ls, 0);
    check("def_scan_frame_start_bad_samples", bad_fs, 0);

    // Enable dropped for 7 Clk at DrawX=100, in the cycle where pixel_ce would be high.
    d_rst = 1'b1;
    @(negedge Clk); @(negedge Clk);
    d_rst = 1'b0;
    repeat (201) @(negedge Clk);
    check("def_hold_entry {x,pce}", {d_x, d_pce}, {10'd100, 1'b1});
    d_en = 1'b0;
    #1;
    check("def_hold_pce_masked", d_pce, 1'b0);
    bad_xy = 0;
    for (int j = 0; j < 7; j++) begin
      @(negedge Clk);
      if ({d_x, d_y, d_hs, d_vs, d_blank, d_pce, d_ls, d_fs} !==
          {10'd100, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}) bad_xy++;
    end
    check("def_hold_bad_cycles", bad_xy, 0);
    d_en = 1'b1;
    #1;
    check("def_resume_phase_pce", d_pce, 1'b1);
    @(negedge Clk);
    check("def_resume1 {x,pce}", {d_x, d_pce}, {10'd101, 1'b0});
    @(negedge Clk);
    check("def_resume2 {x,pce}", {d_x, d_pce}, {10'd101, 1'b1});
    @(negedge Clk);
    check("def_resume3 {x,pce}", {d_x, d_pce}, {10'd102, 1'b0});

    // Six-line raster: full frame scan, wrap boundary, frame period, mid-frame reset.
    m_rst = 1'b1; m_en = 1'b1;
    @(negedge Clk); @(negedge Clk);
    m_rst = 1'b0;
    bad_xy = 0; bad_hs = 0; bad_vs = 0; bad_bl = 0; bad_ls = 0; bad_fs = 0;
    last_fs = 9600; fs_cnt = 0;
    for (int k = 1; k <= 27000; k++) begin
      @(negedge Clk);
      rx   = (k / 2) % 800;
      ry   = (k / 1600) % 6;
      e_hs = !(rx >= 656 && rx <= 751);
      e_vs = (ry != 4);
      e_bl = (rx < 640) && (ry < 3);
      e_ls = (k % 1600) == 0;
      e_fs = (k % 9600) == 0;
      if (k <= 9601) begin
        if (m_x !== 10'(rx) || m_y !== 10'(ry)) bad_xy++;
        if (m_hs !== e_hs) bad_hs++;
        if (m_vs !== e_vs) bad_vs++;
        if (m_blank !== e_bl) bad_bl++;
        if (m_ls !== e_ls) bad_ls++;
        if (m_fs !== e_fs) bad_fs++;
      end
      if (k == 9599) check("mid_pre_wrap {x,y,pce}", {m_x, m_y, m_pce}, {10'd799, 10'd5, 1'b1});
      if (k == 9600) check("mid_wrap {x,y,ls,fs}", {m_x, m_y, m_ls, m_fs}, {10'd0, 10'd0, 1'b1, 1'b1});
      if (k == 9601) check("mid_after_wrap {ls,fs}", {m_ls, m_fs}, {1'b0, 1'b0});
      if (k > 9601 && m_fs === 1'b1) begin
        fs_cnt++;
        check("mid_frame_period", k - last_fs, 9600);
        last_fs = k;
      end
    end
    check("mid_scan_xy_bad_samples", bad_xy, 0);
    check("mid_scan_hs_bad_samples", bad_hs, 0);
    check("mid_scan_vs_bad_samples", bad_vs, 0);
    check("mid_scan_blank_bad_samples", bad_bl, 0);
    check("mid_scan_line_start_bad_samples", bad_ls, 0);
    check("mid_scan_frame_start_bad_samples", bad_fs, 0);
    check("mid_frame_starts_after_first", fs_cnt, 1);
    check("mid_pre_reset {x,y,hs,vs,blank}", {m_x, m_y, m_hs, m_vs, m_blank},
          {10'd700, 10'd4, 1'b0, 1'b0, 1'b0});
    m_rst = 1'b1;
    @(negedge Clk);
    m_rst = 1'b0;
    check("mid_reset {x,y,hs,vs,blank,ls,fs}", {m_x, m_y, m_hs, m_vs, m_blank, m_ls, m_fs},
          {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge Clk);
    check("mid_post_reset1 {x,pce,fs}", {m_x, m_pce, m_fs}, {10'd0, 1'b1, 1'b0});
    @(negedge Clk);
    check("mid_post_reset2 {x,y}", {m_x, m_y}, {10'd1, 10'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
